// File: rtl/cpu_pkg.sv
// Shared types for the CPU front end: fetch FSM states and the {instr, pc} entry
// carried from the fetch stage to decode.
package cpu_pkg;

    localparam int CPU_ADDR_W  = 32;
    localparam int CPU_INSTR_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [CPU_INSTR_W-1:0] instr;
        logic [CPU_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [CPU_ADDR_W-1:0] alignWord(input logic [CPU_ADDR_W-1:0] addr);
        return {addr[CPU_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO of {instr, pc} entries. Flush wins over push,
// and a pop on an empty FIFO or a push on a full one without a pop is ignored.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  fetch_entry_t            pushData,
    input  logic                    pop,
    input  logic                    flush,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output fetch_entry_t            headData
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wrPtr_q;
    logic [PTR_W-1:0]   rdPtr_q;
    logic [CNT_W-1:0]   count_q;
    logic               doPush;
    logic               doPop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign headData = mem_q[rdPtr_q];

    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            unique case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (!reset && !flush && doPush) begin
            mem_q[wrPtr_q] <= pushData;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding req/gnt/rvalid read
// at a time, buffers returned words and discards wrong-path data after a redirect.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = CPU_ADDR_W,
    parameter int                INSTR_W   = CPU_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_pc_plus8
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  fetchPc_q, fetchPc_d;
    logic [ADDR_W-1:0]  reqPc_q, reqPc_d;

    logic               fifoPush, fifoPop, fifoFlush;
    logic               fifoFull, fifoEmpty;
    logic [CNT_W-1:0]   fifoCount;
    fetch_entry_t       pushEntry, headEntry;
    logic               hasSpace;
    logic               granted;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifoPush),
        .pushData (pushEntry),
        .pop      (fifoPop),
        .flush    (fifoFlush),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount),
        .headData (headEntry)
    );

    // Space is judged on the count before any same-cycle pop.
    assign hasSpace  = (fifoCount < CNT_W'(BUF_DEPTH));
    assign pushEntry = '{instr: imem_rdata, pc: reqPc_q};

    assign imem_addr      = fetchPc_q;
    assign instr_valid    = !fifoEmpty;
    assign fifoPop        = instr_valid && instr_ready;
    assign instr          = fifoEmpty ? '0 : headEntry.instr;
    assign instr_pc       = fifoEmpty ? '0 : headEntry.pc;
    assign instr_pc_plus8 = instr_pc + ADDR_W'(8);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            fetchPc_q <= alignWord(RESET_PC);
            reqPc_q   <= '0;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
            reqPc_q   <= reqPc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fetchPc_d = fetchPc_q;
        reqPc_d   = reqPc_q;
        imem_req  = 1'b0;
        granted   = 1'b0;
        fifoPush  = 1'b0;
        fifoFlush = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                imem_req = hasSpace;
                if (hasSpace && imem_gnt) begin
                    granted   = 1'b1;
                    reqPc_d   = fetchPc_q;
                    fetchPc_d = fetchPc_q + ADDR_W'(4);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    fifoPush = !fifoFull || fifoPop;
                    state_d  = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect overrides everything; any read already granted must still drain.
        if (redirect && state_q != S_IDLE) begin
            fifoFlush = 1'b1;
            fifoPush  = 1'b0;
            fetchPc_d = alignWord(redirect_target);
            unique case (state_q)
                S_REQ:           state_d = granted ? S_DRAIN : S_REQ;
                S_WAIT, S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default:         state_d = state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, a stall sequence and a
// randomized run checked against an in-order instruction stream model.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus8;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W    (32),
        .INSTR_W   (32),
        .RESET_PC  (32'h0),
        .BUF_DEPTH (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc_plus8  (instr_pc_plus8)
    );

    int checkCount = 0;
    int passCount  = 0;

    bit          memPending = 1'b0;
    logic [31:0] memPendAddr = '0;
    bit          sampGranted;
    bit          sampRv;
    logic [31:0] sampAddr;

    typedef struct {
        bit          rst, rdy, redir;
        logic [31:0] tgt;
        bit          aG, aR, chk, eReq;
        logic [31:0] eAddr;
        bit          eValid;
        logic [31:0] ePc;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0:   return 32'hE04F000F;
            32'h4:   return 32'hE2801005;
            32'h8:   return 32'hE2802002;
            default: return 32'hE1A00000 ^ a;
        endcase
    endfunction

    function automatic vec_t mk(input bit rst, rdy, redir, input logic [31:0] tgt,
                                input bit aG, aR, chk, eReq, input logic [31:0] eAddr,
                                input bit eValid, input logic [31:0] ePc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.redir = redir; v.tgt = tgt;
        v.aG = aG; v.aR = aR; v.chk = chk; v.eReq = eReq; v.eAddr = eAddr;
        v.eValid = eValid; v.ePc = ePc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    endtask

    // Memory only answers a request it granted, and only when allowed to this cycle.
    task automatic applyStimulus(input bit rst, rdy, redir, input logic [31:0] tgt, input bit aG, aR);
        reset           = rst;
        instr_ready     = rdy;
        redirect        = redir;
        redirect_target = tgt;
        imem_gnt        = imem_req & aG;
        imem_rvalid     = memPending & aR;
        imem_rdata      = (memPending & aR) ? memWord(memPendAddr) : 32'hDEADBEEF;
        @(negedge clk);
        sampGranted = imem_req & imem_gnt;
        sampAddr    = imem_addr;
        sampRv      = imem_rvalid;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (sampRv) memPending = 1'b0;
        if (sampGranted) begin
            checkOutput("oneOutstanding", 32'(memPending), 32'h0);
            memPending  = 1'b1;
            memPendAddr = sampAddr;
        end
    endtask

    task automatic doReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            advance();
        end
        memPending = 1'b0;
    endtask

    initial begin
        bit          prevRst;
        int          grants;
        logic [31:0] gotPcs[$];
        logic [31:0] expNext;
        bit          mustBeEmpty;
        int          consumed;

        reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_target = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        @(posedge clk);
        #1;

        //                rst rdy rd tgt            aG aR chk req addr          vld pc
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'h4,        1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'h8,        1, 32'h4));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'hC,        1, 32'h8));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'h10,       1, 32'hC));
        vecs.push_back(mk(0, 1, 1, 32'h27,       1, 0, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'h24,       0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'h28,       1, 32'h24));
        vecs.push_back(mk(0, 1, 1, 32'h30,       1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h40,       0, 1, 1, 1, 32'h30,       0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'h40,       0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'h44,       1, 32'h40));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 1, 1, 1, 1, 32'h48,       1, 32'h44));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'hFFFFFFFC, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'h0,        1, 32'hFFFFFFFC));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 1, 1, 32'h4,        1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1, 0, 32'h0,        1, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 32'h4,        1, 32'h0));

        prevRst = 1'b0;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].redir, vecs[i].tgt, vecs[i].aG, vecs[i].aR);
            if (vecs[i].chk) begin
                checkOutput($sformatf("vec%0d.req", i), 32'(imem_req), 32'(vecs[i].eReq));
                if (vecs[i].eReq) checkOutput($sformatf("vec%0d.addr", i), imem_addr, vecs[i].eAddr);
                checkOutput($sformatf("vec%0d.valid", i), 32'(instr_valid), 32'(vecs[i].eValid));
                if (vecs[i].eValid) begin
                    checkOutput($sformatf("vec%0d.pc", i), instr_pc, vecs[i].ePc);
                    checkOutput($sformatf("vec%0d.instr", i), instr, memWord(vecs[i].ePc));
                    checkOutput($sformatf("vec%0d.pc8", i), instr_pc_plus8, vecs[i].ePc + 32'd8);
                end
                if (prevRst) begin
                    checkOutput($sformatf("vec%0d.rstInstr", i), instr, 32'h0);
                    checkOutput($sformatf("vec%0d.rstPc", i), instr_pc, 32'h0);
                end
            end
            prevRst = vecs[i].rst;
            advance();
        end

        // Decode stalled: only BUF_DEPTH words may be fetched, then requests stop.
        doReset();
        grants = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (sampGranted) grants++;
            advance();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("stallNoReq", 32'(imem_req), 32'h0);
        checkOutput("stallGrants", 32'(grants), 32'd2);
        checkOutput("stallValid", 32'(instr_valid), 32'h1);
        checkOutput("stallHeadPc", instr_pc, 32'h0);
        advance();
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            if (instr_valid && gotPcs.size() < 3) gotPcs.push_back(instr_pc);
            advance();
        end
        checkOutput("releaseCount", 32'(gotPcs.size()), 32'd3);
        for (int k = 0; k < gotPcs.size() && k < 3; k++) begin
            checkOutput($sformatf("releasePc%0d", k), gotPcs[k], 32'(k * 4));
        end

        // Randomized run: consumed words must follow the sequential stream from the last target.
        doReset();
        expNext     = 32'h0;
        mustBeEmpty = 1'b0;
        consumed    = 0;
        for (int c = 0; c < 3000; c++) begin
            bit          rdy, redir, aG, aR;
            logic [31:0] tgt;
            rdy   = ($urandom_range(0, 3) != 0);
            redir = (c > 2) && ($urandom_range(0, 15) == 0);
            aG    = ($urandom_range(0, 3) != 0);
            aR    = ($urandom_range(0, 2) != 0);
            tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                                : 32'($urandom_range(0, 1023));
            applyStimulus(1'b0, rdy, redir, tgt, aG, aR);
            if (mustBeEmpty) checkOutput("flushValid", 32'(instr_valid), 32'h0);
            if (instr_valid && rdy) begin
                checkOutput("rndPc", instr_pc, expNext);
                checkOutput("rndInstr", instr, memWord(expNext));
                checkOutput("rndPc8", instr_pc_plus8, expNext + 32'd8);
                expNext = expNext + 32'd4;
                consumed++;
            end
            if (redir) expNext = tgt & ~32'h3;
            mustBeEmpty = redir;
            advance();
        end
        checkOutput("rndProgress", 32'(consumed > 200), 32'h1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
